spi_target: RTL and testbench

- Memory-mapped SPI responder (target) peripheral on the picorv32 native bus. It is the far end of the SPI protocol that spirom drives as initiator.
- An external SPI master (mode 0, MSB first, 8-bit frames) exchanges bytes with the CPU.
- Received bytes are queued in an RX FIFO. Bytes to send come from a single-entry TX holding register.
- Address decode and the mem_rdata/mem_ready muxing live in hardware.v, like every other peripheral instance.

---
 rtl/spi_target.sv | 185 ++++++++++++++++++
 tb/tb_spi_target.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_target.sv
// rtl/spi_target.sv - SPI mode-0 target peripheral with RX FIFO and single-entry TX holding register
module spi_target #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        valid,
    output logic        ready,
    input  logic [3:0]  wstrb,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        sck_in,
    input  logic        csb_in,
    input  logic        mosi_in,
    output logic        miso_out,
    output logic        miso_iosel,
    output logic        irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic {S_IDLE, S_SEL} state_t;

    state_t        state_q;
    logic [2:0]    sck_q, csb_q;
    logic [1:0]    mosi_q;
    logic          ready_q, miso_out_q, miso_iosel_q, irq_q;
    logic [31:0]   rdata_q;
    logic          enable_q, rx_irq_en_q, overrun_q, underrun_q, under_pend_q;
    logic [7:0]    tx_q, shift_in_q, shift_out_q;
    logic          tx_full_q, byte_done_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;

    logic        sck_rise, sck_fall, csb_fall, csb_rise, bus_fire, bus_wr;
    logic        sel_data, sel_stat, sel_ctrl, pop, tx_write, start, active, leave;
    logic        push_req, push_ok, load, rx_nonempty, rx_full, overrun_set, underrun_set;
    logic [7:0]  rx_byte, load_byte;
    logic [31:0] rd_val;

    always_comb begin
        sck_rise     = sck_q[1] & ~sck_q[2];
        sck_fall     = ~sck_q[1] & sck_q[2];
        csb_fall     = ~csb_q[1] & csb_q[2];
        csb_rise     = csb_q[1] & ~csb_q[2];
        bus_fire     = valid & ~ready_q;
        bus_wr       = |wstrb;
        sel_data     = (addr[3:2] == 2'd0);
        sel_stat     = (addr[3:2] == 2'd1);
        sel_ctrl     = (addr[3:2] == 2'd2);
        rx_nonempty  = (count_q != '0);
        rx_full      = (count_q == FULL_CNT);
        pop          = bus_fire & ~bus_wr & sel_data & rx_nonempty;
        tx_write     = bus_fire & wstrb[0] & sel_data;
        start        = (state_q == S_IDLE) & enable_q & csb_fall;
        active       = (state_q == S_SEL) & enable_q & ~csb_rise;
        leave        = (state_q == S_SEL) & ~active;
        rx_byte      = {shift_in_q[6:0], mosi_q[1]};
        push_req     = active & sck_rise & (bit_cnt_q == 3'd7);
        push_ok      = push_req & (~rx_full | pop);
        load         = start | (active & sck_fall & byte_done_q);
        load_byte    = tx_full_q ? tx_q : 8'hFF;
        overrun_set  = push_req & ~push_ok;
        // A filler byte loaded at a frame's trailing edge only counts as underrun once the master clocks it.
        underrun_set = (start & ~tx_full_q) | (active & sck_rise & under_pend_q);
        rd_val       = 32'h0;
        case (addr[3:2])
            2'd0:    rd_val = rx_nonempty ? {24'h0, fifo_mem[rd_ptr_q]} : 32'h0;
            2'd1:    rd_val = {26'h0, underrun_q, state_q == S_SEL, overrun_q, ~tx_full_q, rx_full, rx_nonempty};
            2'd2:    rd_val = {30'h0, rx_irq_en_q, enable_q};
            default: rd_val = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr_q] <= rx_byte;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            sck_q        <= 3'b000;
            csb_q        <= 3'b111;
            mosi_q       <= 2'b00;
            ready_q      <= 1'b0;
            rdata_q      <= 32'h0;
            miso_out_q   <= 1'b0;
            miso_iosel_q <= 1'b0;
            irq_q        <= 1'b0;
            enable_q     <= 1'b0;
            rx_irq_en_q  <= 1'b0;
            overrun_q    <= 1'b0;
            underrun_q   <= 1'b0;
            under_pend_q <= 1'b0;
            tx_q         <= 8'h0;
            tx_full_q    <= 1'b0;
            shift_in_q   <= 8'h0;
            shift_out_q  <= 8'h0;
            byte_done_q  <= 1'b0;
            bit_cnt_q    <= 3'd0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            sck_q   <= {sck_q[1:0], sck_in};
            csb_q   <= {csb_q[1:0], csb_in};
            mosi_q  <= {mosi_q[0], mosi_in};
            ready_q <= bus_fire;
            rdata_q <= bus_fire ? rd_val : 32'h0;
            irq_q   <= enable_q & rx_irq_en_q & rx_nonempty;

            if (bus_fire && wstrb[0] && sel_ctrl) begin
                enable_q    <= wdata[0];
                rx_irq_en_q <= wdata[1];
            end
            overrun_q  <= (overrun_q & ~(bus_fire & wstrb[0] & sel_stat & wdata[3])) | overrun_set;
            underrun_q <= (underrun_q & ~(bus_fire & wstrb[0] & sel_stat & wdata[5])) | underrun_set;

            // A bus write on a load cycle wins: the load already took the old byte.
            if (tx_write) begin
                tx_q      <= wdata[7:0];
                tx_full_q <= 1'b1;
            end else if (load) begin
                tx_full_q <= 1'b0;
            end

            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q      <= S_SEL;
                        bit_cnt_q    <= 3'd0;
                        byte_done_q  <= 1'b0;
                        under_pend_q <= 1'b0;
                        shift_out_q  <= load_byte;
                        miso_out_q   <= load_byte[7];
                        miso_iosel_q <= 1'b1;
                    end
                end
                S_SEL: begin
                    if (leave) begin
                        state_q      <= S_IDLE;
                        bit_cnt_q    <= 3'd0;
                        byte_done_q  <= 1'b0;
                        under_pend_q <= 1'b0;
                        miso_out_q   <= 1'b0;
                        miso_iosel_q <= 1'b0;
                    end else if (sck_rise) begin
                        shift_in_q   <= rx_byte;
                        bit_cnt_q    <= bit_cnt_q + 3'd1;
                        byte_done_q  <= (bit_cnt_q == 3'd7);
                        under_pend_q <= 1'b0;
                    end else if (sck_fall) begin
                        if (byte_done_q) begin
                            shift_out_q  <= load_byte;
                            miso_out_q   <= load_byte[7];
                            byte_done_q  <= 1'b0;
                            under_pend_q <= ~tx_full_q;
                        end else begin
                            shift_out_q <= {shift_out_q[6:0], 1'b0};
                            miso_out_q  <= shift_out_q[6];
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ready      = ready_q;
    assign rdata      = rdata_q;
    assign miso_out   = miso_out_q;
    assign miso_iosel = miso_iosel_q;
    assign irq        = irq_q;
endmodule

// File: tb/tb_spi_target.sv
// tb/tb_spi_target.sv - self-checking bench for spi_target
module tb_spi_target;
    localparam int HALF = 6;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        valid = 1'b0;
    logic        ready;
    logic [3:0]  wstrb = 4'h0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        sck_in = 1'b0;
    logic        csb_in = 1'b1;
    logic        mosi_in = 1'b0;
    logic        miso_out, miso_iosel, irq;

    int checks = 0;
    int failures = 0;

    spi_target #(.FIFO_DEPTH(4)) dut (
        .clk(clk), .resetn(resetn), .valid(valid), .ready(ready), .wstrb(wstrb),
        .addr(addr), .wdata(wdata), .rdata(rdata), .sck_in(sck_in), .csb_in(csb_in),
        .mosi_in(mosi_in), .miso_out(miso_out), .miso_iosel(miso_iosel), .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    typedef struct {
        logic        wr;
        logic [1:0]  rsel;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic bus_op(input logic wr, input logic [1:0] rsel, input logic [31:0] wd,
                          output logic [31:0] rd);
        int n;
        @(negedge clk);
        valid = 1'b1;
        addr  = {28'h0, rsel, 2'b00};
        wstrb = wr ? 4'hF : 4'h0;
        wdata = wd;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!ready && n < 8);
        if (!ready) check("bus_timeout", {31'h0, ready}, 32'h1);
        rd    = rdata;
        valid = 1'b0;
        wstrb = 4'h0;
    endtask

    task automatic bus_wr(input logic [1:0] rsel, input logic [31:0] wd);
        logic [31:0] dummy;
        bus_op(1'b1, rsel, wd, dummy);
    endtask

    task automatic bus_chk(input string name, input logic [1:0] rsel, input logic [31:0] exp);
        logic [31:0] rd;
        bus_op(1'b0, rsel, 32'h0, rd);
        check(name, rd, exp);
    endtask

    task automatic spi_select();
        @(negedge clk);
        csb_in = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic spi_deselect();
        repeat (HALF) @(negedge clk);
        csb_in = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    // mode 0: plain byte; 1: bus DATA read lands on the 8th-bit push; 2: watch irq around the push
    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx, input int mode);
        for (int i = 7; i >= 0; i--) begin
            mosi_in = tx[i];
            repeat (HALF) @(negedge clk);
            rx[i] = miso_out;
            sck_in = 1'b1;
            if (i == 0 && mode == 1) begin
                repeat (2) @(negedge clk);
                valid = 1'b1;
                addr  = 32'h0;
                wstrb = 4'h0;
                @(posedge clk); #1;
                check("collide_ready", {31'h0, ready}, 32'h1);
                check("collide_rdata", rdata, 32'h11);
                valid = 1'b0;
                repeat (HALF - 3) @(negedge clk);
            end else if (i == 0 && mode == 2) begin
                repeat (3) @(posedge clk); #1;
                check("irq_at_push", {31'h0, irq}, 32'h0);
                @(posedge clk); #1;
                check("irq_after_push", {31'h0, irq}, 32'h1);
                repeat (HALF - 4) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            sck_in = 1'b0;
        end
    endtask

    task automatic sck_bits(input int n);
        for (int i = 0; i < n; i++) begin
            mosi_in = i[0];
            repeat (HALF) @(negedge clk);
            sck_in = 1'b1;
            repeat (HALF) @(negedge clk);
            sck_in = 1'b0;
        end
    endtask

    initial begin
        vec_t        tbl [15];
        logic [7:0]  rx;
        logic [31:0] rd;

        tbl[0]  = '{1'b0, 2'd1, 32'h0,        32'h04};
        tbl[1]  = '{1'b0, 2'd2, 32'h0,        32'h00};
        tbl[2]  = '{1'b0, 2'd0, 32'h0,        32'h00};
        tbl[3]  = '{1'b0, 2'd3, 32'h0,        32'h00};
        tbl[4]  = '{1'b1, 2'd2, 32'hFF,       32'h00};
        tbl[5]  = '{1'b0, 2'd2, 32'h0,        32'h03};
        tbl[6]  = '{1'b1, 2'd3, 32'hFFFFFFFF, 32'h00};
        tbl[7]  = '{1'b0, 2'd3, 32'h0,        32'h00};
        tbl[8]  = '{1'b1, 2'd0, 32'h12,       32'h00};
        tbl[9]  = '{1'b0, 2'd1, 32'h0,        32'h00};
        tbl[10] = '{1'b1, 2'd0, 32'h34,       32'h00};
        tbl[11] = '{1'b1, 2'd1, 32'h28,       32'h00};
        tbl[12] = '{1'b0, 2'd1, 32'h0,        32'h00};
        tbl[13] = '{1'b1, 2'd2, 32'h0,        32'h00};
        tbl[14] = '{1'b0, 2'd2, 32'h0,        32'h00};

        repeat (4) @(negedge clk);
        @(posedge clk); #1;
        check("rst_ready", {31'h0, ready}, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_miso", {30'h0, miso_out, miso_iosel}, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < 15; i++) begin
            bus_op(tbl[i].wr, tbl[i].rsel, tbl[i].wd, rd);
            if (!tbl[i].wr) check($sformatf("tbl%0d", i), rd, tbl[i].exp);
        end

        // basic exchange
        bus_wr(2'd2, 32'h1);
        bus_wr(2'd0, 32'hA5);
        spi_select();
        check("basic_iosel", {31'h0, miso_iosel}, 32'h1);
        spi_byte(8'h3C, rx, 0);
        check("basic_miso", {24'h0, rx}, 32'hA5);
        spi_deselect();
        bus_chk("basic_status", 2'd1, 32'h05);
        bus_chk("basic_data", 2'd0, 32'h3C);
        bus_chk("basic_empty", 2'd0, 32'h00);
        bus_chk("basic_status2", 2'd1, 32'h04);

        // underrun and overrun
        spi_select();
        for (int b = 1; b <= 5; b++) begin
            spi_byte(8'(b), rx, 0);
            check($sformatf("uo_miso%0d", b), {24'h0, rx}, 32'hFF);
        end
        spi_deselect();
        bus_chk("uo_status", 2'd1, 32'h2F);
        for (int b = 1; b <= 4; b++) bus_chk($sformatf("uo_data%0d", b), 2'd0, 32'(b));
        bus_chk("uo_empty", 2'd0, 32'h00);
        bus_wr(2'd1, 32'h28);
        bus_chk("uo_cleared", 2'd1, 32'h04);

        // chip-select abort after 5 SCK edges
        bus_wr(2'd0, 32'h5A);
        spi_select();
        for (int e = 0; e < 5; e++) begin
            mosi_in = 1'b1;
            repeat (HALF) @(negedge clk);
            sck_in = ~sck_in;
        end
        repeat (HALF) @(negedge clk);
        csb_in = 1'b1;
        repeat (2) @(posedge clk); #1;
        check("abort_iosel_early", {31'h0, miso_iosel}, 32'h1);
        @(posedge clk); #1;
        check("abort_iosel_off", {30'h0, miso_iosel, miso_out}, 32'h0);
        @(negedge clk);
        sck_in = 1'b0;
        repeat (HALF) @(negedge clk);
        bus_chk("abort_status", 2'd1, 32'h04);
        bus_wr(2'd0, 32'h66);
        spi_select();
        spi_byte(8'h99, rx, 0);
        check("abort_next_miso", {24'h0, rx}, 32'h66);
        spi_deselect();
        bus_chk("abort_next_status", 2'd1, 32'h05);
        bus_chk("abort_next_data", 2'd0, 32'h99);

        // pop/push collision with a full FIFO
        spi_select();
        for (int b = 1; b <= 4; b++) spi_byte(8'(b * 8'h11), rx, 0);
        spi_byte(8'h55, rx, 1);
        spi_deselect();
        bus_chk("coll_status", 2'd1, 32'h27);
        bus_chk("coll_d1", 2'd0, 32'h22);
        bus_chk("coll_d2", 2'd0, 32'h33);
        bus_chk("coll_d3", 2'd0, 32'h44);
        bus_chk("coll_d4", 2'd0, 32'h55);
        bus_chk("coll_empty", 2'd0, 32'h00);
        bus_wr(2'd1, 32'h28);

        // interrupt and handshake
        bus_wr(2'd2, 32'h3);
        check("irq_idle", {31'h0, irq}, 32'h0);
        spi_select();
        spi_byte(8'h77, rx, 2);
        spi_deselect();
        @(negedge clk);
        valid = 1'b1;
        addr  = 32'h0;
        wstrb = 4'h0;
        @(posedge clk); #1;
        check("hs_c1_ready", {31'h0, ready}, 32'h1);
        check("hs_c1_rdata", rdata, 32'h77);
        check("hs_c1_irq", {31'h0, irq}, 32'h1);
        @(posedge clk); #1;
        check("hs_c2_ready", {31'h0, ready}, 32'h0);
        check("hs_c2_rdata", rdata, 32'h0);
        check("hs_c2_irq", {31'h0, irq}, 32'h0);
        valid = 1'b0;
        @(posedge clk); #1;
        check("hs_c3_ready", {31'h0, ready}, 32'h0);
        bus_chk("hs_empty", 2'd1, 32'h24);
        bus_wr(2'd1, 32'h28);

        // reset mid-byte
        bus_wr(2'd2, 32'h1);
        bus_wr(2'd0, 32'h42);
        spi_select();
        sck_bits(4);
        @(negedge clk);
        resetn = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_bus", {31'h0, ready} | rdata, 32'h0);
        check("mid_rst_spi", {29'h0, miso_out, miso_iosel, irq}, 32'h0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        sck_bits(4);
        check("post_rst_iosel", {31'h0, miso_iosel}, 32'h0);
        spi_deselect();
        bus_chk("post_rst_status", 2'd1, 32'h04);
        bus_chk("post_rst_data", 2'd0, 32'h00);
        bus_chk("post_rst_ctrl", 2'd2, 32'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
